// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: FSM states,
// default geometry and the byte-enable merge used by writes and bypass.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MAX_DATA_W = 256;

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0]   old_w,
    input logic [MAX_DATA_W-1:0]   new_w,
    input logic [MAX_DATA_W/8-1:0] be
  );
    logic [MAX_DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_DATA_W / 8; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: 1-cycle latency; while busy the port reports
// rd_valid=0 and holds data. Same-cycle write forwarding under REGFILE_BYPASS_EN.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  DEPTH    = DEF_DEPTH,
  parameter int  ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    busy_i,
  input  logic [DEPTH*DATA_W-1:0] mem_i,
  input  logic                    rd_en_i,
  input  logic [ADDR_W-1:0]       rd_addr_i,
`ifdef REGFILE_BYPASS_EN
  input  logic                    wr_fire_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [DATA_W/8-1:0]     wr_be_i,
  input  logic [DATA_W-1:0]       wr_data_i,
`endif
  output logic [DATA_W-1:0]       rd_data_o,
  output logic                    rd_valid_o
);

  logic              in_range;
  logic              zero_hit;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_valid_d, rd_valid_q;

  always_comb begin
    in_range = 32'(rd_addr_i) < DEPTH;
    zero_hit = (ZERO_REG != 0) && (rd_addr_i == '0);
    idx      = in_range ? rd_addr_i : '0;
    word     = mem_i[32'(idx)*DATA_W +: DATA_W];
`ifdef REGFILE_BYPASS_EN
    // wr_fire_i already excludes dropped writes and the hardwired-zero entry.
    if (wr_fire_i && (wr_addr_i == rd_addr_i)) begin
      word = DATA_W'(byte_merge(MAX_DATA_W'(word), MAX_DATA_W'(wr_data_i),
                                (MAX_DATA_W/8)'(wr_be_i)));
    end
`endif
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_en_i && !busy_i) begin
      rd_valid_d = 1'b1;
      rd_data_d  = (in_range && !zero_hit) ? word : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardware clear sequencer (DEPTH cycles after reset/clr_req).
// Reads 1-cycle latency; writes/reads during busy are dropped. Optional REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  DEPTH    = DEF_DEPTH,
  parameter int  NUM_RD   = DEF_NUM_RD,
  parameter int  ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W/8-1:0]      wr_be_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_valid_o,
  input  logic                     clr_req_i,
  output logic                     busy_o,
  output logic                     wr_err_o
);

  state_e            state_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic              wr_err_q;

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;

  logic              wr_in_range;
  logic              wr_fire;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_merged;

  always_comb begin
    wr_in_range = 32'(wr_addr_i) < DEPTH;
    wr_fire     = wr_en_i && (state_q == IDLE) && wr_in_range &&
                  !((ZERO_REG != 0) && (wr_addr_i == '0));
    wr_idx      = wr_in_range ? wr_addr_i : '0;
    wr_merged   = DATA_W'(byte_merge(MAX_DATA_W'(mem_q[wr_idx]), MAX_DATA_W'(wr_data_i),
                                     (MAX_DATA_W/8)'(wr_be_i)));
    for (int i = 0; i < DEPTH; i++) mem_flat[i*DATA_W +: DATA_W] = mem_q[i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      wr_err_q <= wr_en_i && ((state_q == CLEAR) || !wr_in_range);
      case (state_q)
        CLEAR: begin
          if (32'(clr_idx_q) == DEPTH - 1) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (clr_req_i) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
          end
        end
      endcase
    end
  end

  // Storage has no reset of its own; the clear sequence zeroes it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == CLEAR) mem_q[clr_idx_q] <= '0;
      else if (wr_fire)     mem_q[wr_addr_i] <= wr_merged;
    end
  end

  assign busy_o   = (state_q == CLEAR);
  assign wr_err_o = wr_err_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .busy_i    (busy_o),
      .mem_i     (mem_flat),
      .rd_en_i   (rd_en_i[p]),
      .rd_addr_i (rd_addr_i[p*ADDR_W +: ADDR_W]),
`ifdef REGFILE_BYPASS_EN
      .wr_fire_i (wr_fire),
      .wr_addr_i (wr_addr_i),
      .wr_be_i   (wr_be_i),
      .wr_data_i (wr_data_i),
`endif
      .rd_data_o (rd_data_o[p*DATA_W +: DATA_W]),
      .rd_valid_o(rd_valid_o[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: DEPTH=32 main instance plus a DEPTH=20 instance for range checks.
module tb_regfile_mp;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [3:0]    wr_be = '0;
  logic [31:0]   wr_data = '0;
  logic [1:0]    rd_en = '0;
  logic [2*AW-1:0] rd_addr = '0;
  logic          clr_req = 1'b0;

  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_valid_a, rd_valid_b;
  logic        busy_a, busy_b, wr_err_a, wr_err_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] qb[$];
  logic [31:0] model [32];

  regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
    .rd_valid_o(rd_valid_a), .clr_req_i(clr_req), .busy_o(busy_a), .wr_err_o(wr_err_a));

  regfile_mp #(.DATA_W(32), .DEPTH(20), .NUM_RD(2), .ZERO_REG(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .rd_valid_o(rd_valid_b), .clr_req_i(clr_req), .busy_o(busy_b), .wr_err_o(wr_err_b));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_be = '0; rd_en = '0; clr_req = 1'b0;
  endtask

  task automatic write(input int a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_be = be;
  endtask

  task automatic read(input int p, input int a, input logic [31:0] e);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
    if (p == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  function automatic logic [31:0] pop_exp(input int p);
    if (p == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int pending(input int p);
    return (p == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic test_reset();
    int cnt;
    int cnt_b;
    rst = 1'b1; idle_inputs();
    step(); step();
    n_tests++;
    if (busy_a !== 1'b1 || rd_valid_a !== 2'b00 || wr_err_a !== 1'b0 || rd_data_a !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b valid=%b err=%b data=%h, want 1 00 0 0",
               busy_a, rd_valid_a, wr_err_a, rd_data_a);
    end
    rst = 1'b0;
    cnt = 0; cnt_b = 0;
    while (busy_a === 1'b1 && cnt < 100) begin
      step(); cnt++;
      if (busy_b === 1'b0 && cnt_b == 0) cnt_b = cnt;
    end
    n_tests++;
    if (cnt != 32) begin n_fail++; $display("FAIL reset_busy_len: got %0d cycles, want 32", cnt); end
    n_tests++;
    if (cnt_b != 20) begin n_fail++; $display("FAIL reset_busy_len_d20: got %0d cycles, want 20", cnt_b); end
    for (int i = 0; i < 32; i++) begin
      read(0, i, 32'h0); read(1, 31 - i, 32'h0);
      step();
      for (int p = 0; p < 2; p++) if (pending(p) > 0) begin
        logic [31:0] e;
        e = pop_exp(p); n_tests++;
        if (rd_valid_a[p] !== 1'b1 || rd_data_a[p*32 +: 32] !== e) begin
          n_fail++;
          $display("FAIL reset_read p%0d: valid=%b data=%h, want valid=1 data=%h",
                   p, rd_valid_a[p], rd_data_a[p*32 +: 32], e);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_byte_merge();
    write(5, 32'h11223344, 4'hF); step();
    write(5, 32'hDEADBEEF, 4'b0101); step();
    n_tests++;
    if (wr_err_a !== 1'b0) begin n_fail++; $display("FAIL merge_err: got %b, want 0", wr_err_a); end
    write(5, 32'h0, 4'h0);
    read(0, 5, 32'h11AD33EF);
    step();
    n_tests++;
    if (wr_err_a !== 1'b0) begin n_fail++; $display("FAIL be0_err: got %b, want 0", wr_err_a); end
    for (int p = 0; p < 2; p++) if (pending(p) > 0) begin
      logic [31:0] e;
      e = pop_exp(p); n_tests++;
      if (rd_valid_a[p] !== 1'b1 || rd_data_a[p*32 +: 32] !== e) begin
        n_fail++;
        $display("FAIL merge_read p%0d: valid=%b data=%h, want valid=1 data=%h",
                 p, rd_valid_a[p], rd_data_a[p*32 +: 32], e);
      end
    end
    idle_inputs();
  endtask

  task automatic test_collision();
    logic [31:0] coll;
`ifdef REGFILE_BYPASS_EN
    coll = 32'hCAFEF00D;
`else
    coll = 32'h11AD33EF;
`endif
    for (int k = 0; k < 2; k++) begin
      if (k == 0) write(5, 32'hCAFEF00D, 4'hF);
      read(0, 5, (k == 0) ? coll : 32'hCAFEF00D);
      read(1, 5, (k == 0) ? coll : 32'hCAFEF00D);
      step(); idle_inputs();
      for (int p = 0; p < 2; p++) if (pending(p) > 0) begin
        logic [31:0] e;
        e = pop_exp(p); n_tests++;
        if (rd_valid_a[p] !== 1'b1 || rd_data_a[p*32 +: 32] !== e) begin
          n_fail++;
          $display("FAIL collision%0d p%0d: valid=%b data=%h, want valid=1 data=%h",
                   k, p, rd_valid_a[p], rd_data_a[p*32 +: 32], e);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) write(0, 32'hFFFFFFFF, 4'hF);
      read(k, 0, 32'h0);
      step(); idle_inputs();
      n_tests++;
      if (wr_err_a !== 1'b0) begin n_fail++; $display("FAIL zero_err%0d: got %b, want 0", k, wr_err_a); end
      for (int p = 0; p < 2; p++) if (pending(p) > 0) begin
        logic [31:0] e;
        e = pop_exp(p); n_tests++;
        if (rd_valid_a[p] !== 1'b1 || rd_data_a[p*32 +: 32] !== e) begin
          n_fail++;
          $display("FAIL zero_read%0d p%0d: valid=%b data=%h, want valid=1 data=%h",
                   k, p, rd_valid_a[p], rd_data_a[p*32 +: 32], e);
        end
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] e;
    write(25, 32'h12345678, 4'hF); step(); idle_inputs();
    n_tests++;
    if (wr_err_b !== 1'b1) begin n_fail++; $display("FAIL range_err: got %b, want 1", wr_err_b); end
    rd_en[0] = 1'b1; rd_addr[0 +: AW] = AW'(25); qb.push_back(32'h0);
    step(); idle_inputs();
    n_tests++;
    if (wr_err_b !== 1'b0) begin n_fail++; $display("FAIL range_err_pulse: got %b, want 0", wr_err_b); end
    e = qb.pop_front(); n_tests++;
    if (rd_valid_b[0] !== 1'b1 || rd_data_b[31:0] !== e) begin
      n_fail++;
      $display("FAIL range_read: valid=%b data=%h, want valid=1 data=%h", rd_valid_b[0], rd_data_b[31:0], e);
    end
    write(19, 32'hA5A55A5A, 4'hF); step(); idle_inputs();
    n_tests++;
    if (wr_err_b !== 1'b0) begin n_fail++; $display("FAIL last_entry_err: got %b, want 0", wr_err_b); end
    rd_en[1] = 1'b1; rd_addr[AW +: AW] = AW'(19); qb.push_back(32'hA5A55A5A);
    step(); idle_inputs();
    e = qb.pop_front(); n_tests++;
    if (rd_valid_b[1] !== 1'b1 || rd_data_b[63:32] !== e) begin
      n_fail++;
      $display("FAIL last_entry_read: valid=%b data=%h, want valid=1 data=%h", rd_valid_b[1], rd_data_b[63:32], e);
    end
  endtask

  task automatic test_clear();
    int cnt;
    logic [31:0] prev;
    write(1, 32'h01010101, 4'hF); step();
    write(2, 32'h02020202, 4'hF); step();
    write(3, 32'h03030303, 4'hF); read(0, 1, 32'h01010101); step();
    write(4, 32'h04040404, 4'hF); clr_req = 1'b1;
    for (int p = 0; p < 2; p++) if (pending(p) > 0) begin
      logic [31:0] e;
      e = pop_exp(p); n_tests++;
      if (rd_valid_a[p] !== 1'b1 || rd_data_a[p*32 +: 32] !== e) begin
        n_fail++;
        $display("FAIL fill_read p%0d: valid=%b data=%h, want valid=1 data=%h",
                 p, rd_valid_a[p], rd_data_a[p*32 +: 32], e);
      end
    end
    rd_en = '0;
    step(); idle_inputs();
    prev = rd_data_a[31:0];
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 100) begin
      if (cnt == 0) write(7, 32'h77777777, 4'hF);
      if (cnt == 1) begin rd_en[0] = 1'b1; rd_addr[0 +: AW] = AW'(1); end
      if (cnt == 5) clr_req = 1'b1;
      step(); cnt++; idle_inputs();
      if (cnt == 1) begin
        n_tests++;
        if (wr_err_a !== 1'b1) begin n_fail++; $display("FAIL busy_wr_err: got %b, want 1", wr_err_a); end
      end
      if (cnt == 2) begin
        n_tests++;
        if (rd_valid_a[0] !== 1'b0 || rd_data_a[31:0] !== prev) begin
          n_fail++;
          $display("FAIL busy_read: valid=%b data=%h, want valid=0 data=%h", rd_valid_a[0], rd_data_a[31:0], prev);
        end
      end
    end
    n_tests++;
    if (cnt != 32) begin n_fail++; $display("FAIL clear_busy_len: got %0d cycles, want 32", cnt); end
    for (int i = 0; i < 32; i++) begin
      read(0, i, 32'h0); read(1, i, 32'h0);
      step();
      for (int p = 0; p < 2; p++) if (pending(p) > 0) begin
        logic [31:0] e;
        e = pop_exp(p); n_tests++;
        if (rd_valid_a[p] !== 1'b1 || rd_data_a[p*32 +: 32] !== e) begin
          n_fail++;
          $display("FAIL post_clear p%0d addr%0d: valid=%b data=%h, want valid=1 data=%h",
                   p, i, rd_valid_a[p], rd_data_a[p*32 +: 32], e);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_rst_mid_clear();
    int cnt;
    clr_req = 1'b1; step(); idle_inputs();
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1; step();
    n_tests++;
    if (busy_a !== 1'b1 || rd_valid_a !== 2'b00) begin
      n_fail++; $display("FAIL mid_rst_state: busy=%b valid=%b, want 1 00", busy_a, rd_valid_a);
    end
    rst = 1'b0;
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 100) begin step(); cnt++; end
    n_tests++;
    if (cnt != 32) begin n_fail++; $display("FAIL mid_rst_busy_len: got %0d cycles, want 32", cnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int i = 1; i <= 24; i++) begin
      int a;
      int pa;
      logic [31:0] d;
      logic [3:0]  be;
      logic [31:0] nv;
      a  = (i % 8) + 1;
      pa = ((i - 1) % 8) + 1;
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      nv = merge(model[a], d, be);
      write(a, d, be);
      read(0, pa, model[pa]);
`ifdef REGFILE_BYPASS_EN
      read(1, a, nv);
`else
      read(1, a, model[a]);
`endif
      model[a] = nv;
      step(); idle_inputs();
      for (int p = 0; p < 2; p++) if (pending(p) > 0) begin
        logic [31:0] e;
        e = pop_exp(p); n_tests++;
        if (rd_valid_a[p] !== 1'b1 || rd_data_a[p*32 +: 32] !== e) begin
          n_fail++;
          $display("FAIL b2b%0d p%0d: valid=%b data=%h, want valid=1 data=%h",
                   i, p, rd_valid_a[p], rd_data_a[p*32 +: 32], e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_merge();
    test_collision();
    test_zero_reg();
    test_range();
    test_clear();
    test_rst_mid_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

endmodule
